// File: rtl/seq_divider_16by8.sv
// -----------------------------------------------------------------------------
// seq_divider_16by8
//
// Iterative restoring divider. It accepts a DIVIDEND_W-bit unsigned dividend
// and a DIVISOR_W-bit unsigned divisor, and resolves one quotient bit per clock.
// It returns a registered DIVIDEND_W-bit quotient and a DIVISOR_W-bit remainder.
// Both the input side and the result side use a valid/ready handshake.
// A zero divisor skips the iteration and returns quotient = all ones,
// remainder = 0 and div_by_zero = 1 on the cycle after the accept.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; discards any in-flight division
//   in_valid     operands valid
//   in_ready     block can accept operands (IDLE)
//   dividend     unsigned dividend, DIVIDEND_W bits
//   divisor      unsigned divisor, DIVISOR_W bits
//   out_valid    result valid (DONE)
//   out_ready    consumer accepts the result
//   quotient     registered quotient, held until the next result
//   remainder    registered remainder, held until the next result
//   div_by_zero  the current result came from a zero divisor
//   busy         high while a division is in progress or a result is pending
// -----------------------------------------------------------------------------
module seq_divider_16by8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  busy
);

    localparam int CNT_W = $clog2(DIVIDEND_W);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    // The dividend shifts out of the MSB while quotient bits shift into the
    // LSB of the same register. After the last step it holds the quotient.
    logic [DIVIDEND_W-1:0]   shift_q, shift_d;
    // After each restore the partial remainder is below the divisor, so it
    // needs only DIVISOR_W bits to store. The shifted trial value is one bit wider.
    logic [DIVISOR_W-1:0]    rem_q, rem_d;
    logic [DIVISOR_W-1:0]    divisor_q, divisor_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
    logic                    dbz_q, dbz_d;

    logic [DIVISOR_W:0]      rem_shift;
    logic [DIVISOR_W-1:0]    rem_sub;
    logic [DIVISOR_W-1:0]    rem_step;
    logic                    q_bit;

    // ---------------------------------------------------------------- step logic
    always_comb begin
        rem_shift = {rem_q, shift_q[DIVIDEND_W-1]};
        q_bit     = (rem_shift >= {1'b0, divisor_q});
        // When q_bit is set, the true difference is below the divisor, so it
        // fits in DIVISOR_W bits. A modulo subtraction on the low bits is exact.
        rem_sub   = rem_shift[DIVISOR_W-1:0] - divisor_q;
        rem_step  = q_bit ? rem_sub : rem_shift[DIVISOR_W-1:0];
    end

    // ------------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so that every flop
        // samples the pre-edge values. Blocking here would create order-dependent races.
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            rem_q       <= '0;
            divisor_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rem_q       <= rem_d;
            divisor_q   <= divisor_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        // NOTE: assign a default before the case so that no path leaves
        // state_d unassigned. An unassigned path would infer a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
            CALC: if (count_q == '0) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------ datapath
    always_comb begin
        shift_d     = shift_q;
        rem_d       = rem_q;
        divisor_d   = divisor_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = dividend;
                    divisor_d = divisor;
                    rem_d     = '0;
                    count_d   = CNT_INIT;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = '0;
                        dbz_d       = 1'b1;
                    end
                end
            end
            CALC: begin
                shift_d = {shift_q[DIVIDEND_W-2:0], q_bit};
                rem_d   = rem_step;
                if (count_q == '0) begin
                    quotient_d  = {shift_q[DIVIDEND_W-2:0], q_bit};
                    remainder_d = rem_step;
                    dbz_d       = 1'b0;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// -----------------------------------------------------------------------------
// tb_seq_divider_16by8
//
// Bench for seq_divider_16by8. Directed vectors come from a table. Hand
// sequences exercise backpressure and a mid-operation reset. A randomised run
// then issues back-to-back divisions with random stalls on the result side.
// Expected results are pushed to a scoreboard queue when operands are accepted,
// and popped when the DUT presents its result. The bench drives inputs and
// samples outputs on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_seq_divider_16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        busy;

    always #5 clk = ~clk;

    seq_divider_16by8 #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
    );

    typedef struct packed {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } res_t;

    typedef struct packed {
        res_t       res;
        logic [7:0] lat;   // edges from the accept edge to out_valid
    } vec_t;

    res_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic res_t mk(input logic [15:0] dvd, input logic [7:0] dvs,
                                input logic [15:0] q, input logic [7:0] r, input logic dbz);
        res_t e;
        e.dvd = dvd; e.dvs = dvs; e.q = q; e.r = r; e.dbz = dbz;
        return e;
    endfunction

    // Reference model: plain integer division.
    function automatic res_t model(input logic [15:0] dvd, input logic [7:0] dvs);
        if (dvs == 8'd0) return mk(dvd, dvs, 16'hFFFF, 8'd0, 1'b1);
        return mk(dvd, dvs, 16'(int'(dvd) / int'(dvs)), 8'(int'(dvd) % int'(dvs)), 1'b0);
    endfunction

    // Present operands, wait for in_ready, and let one rising edge accept them.
    task automatic accept(input res_t e);
        int n;
        dividend = e.dvd;
        divisor  = e.dvs;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        sb.push_back(e);
    endtask

    // Count edges after the accept edge until out_valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    // Compare the presented result with the scoreboard, then hand it off.
    task automatic take_result(input string tag);
        res_t        e;
        logic [31:0] recon;
        if (sb.size() == 0) begin
            total++;
            $display("FAIL %s.scoreboard: result present, expected none queued", tag);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s.q", tag), quotient, e.q);
            check($sformatf("%s.r", tag), remainder, e.r);
            check($sformatf("%s.dbz", tag), div_by_zero, e.dbz);
            if (!e.dbz) begin
                recon = 32'(quotient) * 32'(e.dvs) + 32'(remainder);
                check($sformatf("%s.invariant", tag), recon, 32'(e.dvd));
                check($sformatf("%s.r_lt_d", tag), 32'(remainder < e.dvs), 1);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check($sformatf("%s.idle_after", tag), {30'd0, in_ready, out_valid}, 32'b10);
            check($sformatf("%s.q_held", tag), quotient, e.q);
        end
    endtask

    vec_t tbl [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int stall;
        logic saw_valid;
        logic [15:0] rd;
        logic [7:0]  rv;

        tbl = '{
            '{mk(16'd65535, 8'd255, 16'd257,   8'd0,   1'b0), 8'd16},
            '{mk(16'd1000,  8'd7,   16'd142,   8'd6,   1'b0), 8'd16},
            '{mk(16'd5,     8'd9,   16'd0,     8'd5,   1'b0), 8'd16},
            '{mk(16'd0,     8'd5,   16'd0,     8'd0,   1'b0), 8'd16},
            '{mk(16'd12345, 8'd0,   16'hFFFF,  8'd0,   1'b1), 8'd0},
            '{mk(16'd200,   8'd1,   16'd200,   8'd0,   1'b0), 8'd16},
            '{mk(16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0), 8'd16},
            '{mk(16'd256,   8'd255, 16'd1,     8'd1,   1'b0), 8'd16},
            '{mk(16'd65535, 8'd128, 16'd511,   8'd127, 1'b0), 8'd16},
            '{mk(16'd254,   8'd255, 16'd0,     8'd254, 1'b0), 8'd16}
        };

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("rst.in_ready", in_ready, 1);
        check("rst.busy", busy, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.quotient", quotient, 0);
        check("rst.remainder", remainder, 0);
        check("rst.div_by_zero", div_by_zero, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            accept(tbl[i].res);
            if (tbl[i].lat != 0) check($sformatf("vec%0d.calc_state", i), {30'd0, busy, in_ready}, 32'b10);
            wait_valid(n);
            check($sformatf("vec%0d.latency", i), n, 32'(tbl[i].lat));
            take_result($sformatf("vec%0d", i));
        end

        // Backpressure: result stalled for 5 cycles while new operands wait.
        accept(mk(16'd40000, 8'd200, 16'd200, 8'd0, 1'b0));
        wait_valid(n);
        check("bp.latency", n, 16);
        dividend = 16'd9; divisor = 8'd3; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp.stall%0d.flags", c), {29'd0, out_valid, in_ready, busy}, 32'b101);
            check($sformatf("bp.stall%0d.q", c), quotient, 200);
            check($sformatf("bp.stall%0d.r", c), remainder, 0);
        end
        take_result("bp");
        accept(mk(16'd9, 8'd3, 16'd3, 8'd0, 1'b0));
        wait_valid(n);
        check("bp2.latency", n, 16);
        take_result("bp2");

        // Reset on the 8th CALC edge discards the division.
        accept(mk(16'd50000, 8'd77, 16'd649, 8'd27, 1'b0));
        sb.delete();
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst.busy", busy, 0);
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready", in_ready, 1);
        check("midrst.quotient", quotient, 0);
        check("midrst.remainder", remainder, 0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            saw_valid |= out_valid;
        end
        check("midrst.no_result", saw_valid, 0);
        accept(mk(16'd100, 8'd3, 16'd33, 8'd1, 1'b0));
        wait_valid(n);
        check("midrst2.latency", n, 16);
        take_result("midrst2");

        // Randomised back-to-back run with result-side stalls.
        for (int i = 0; i < 2000; i++) begin
            rd = 16'($urandom);
            rv = 8'($urandom_range(1, 255));
            accept(model(rd, rv));
            wait_valid(n);
            check($sformatf("rnd%0d.latency", i), n, 16);
            stall = $urandom_range(0, 3);
            repeat (stall) @(negedge clk);
            take_result($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
